bit4_full_adder: RTL and testbench



---
 rtl/bit4_add_pkg.sv | 5 +
 rtl/half_adder.sv | 11 +
 rtl/bit4_full_adder.sv | 73 +++++++
 tb/tb_bit4_full_adder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bit4_add_pkg.sv
// Shared widths for the registered 4-bit adder and its helpers.
package bit4_add_pkg;
  localparam int ADD_W = 4;
  localparam int RES_W = ADD_W + 1;
endpackage

// File: rtl/half_adder.sv
// Single-bit half adder: s = x ^ y, c = x & y.
// Purely combinational, zero latency, no flow control.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/bit4_full_adder.sv
// Registered 4-bit ripple-carry adder with carry-in; result appears one clock after a valid operand set.
// Accepts one operand set per clock with no backpressure; outputs hold when i_valid is low.
module bit4_full_adder
  import bit4_add_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [ADD_W-1:0] i_a,
  input  logic [ADD_W-1:0] i_b,
  input  logic             i_cin,
  output logic [ADD_W-1:0] o_sum,
  output logic             o_carry,
  output logic             o_valid
);

  logic [ADD_W:0]   carry;
  logic [ADD_W-1:0] prop;
  logic [ADD_W-1:0] gen_ab;
  logic [ADD_W-1:0] gen_pc;
  logic [ADD_W-1:0] sum_comb;

  assign carry[0] = i_cin;

  // Each stage: first half adder combines the operand bits, second folds in the ripple carry.
  for (genvar k = 0; k < ADD_W; k++) begin : g_stage
    half_adder u_ha_ab (
      .x (i_a[k]),
      .y (i_b[k]),
      .s (prop[k]),
      .c (gen_ab[k])
    );
    half_adder u_ha_pc (
      .x (prop[k]),
      .y (carry[k]),
      .s (sum_comb[k]),
      .c (gen_pc[k])
    );
    assign carry[k+1] = gen_ab[k] | gen_pc[k];
  end

  logic [ADD_W-1:0] sum_d,   sum_q;
  logic             carry_d, carry_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (i_valid) begin
      sum_d   = sum_comb;
      carry_d = carry[ADD_W];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = carry_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_bit4_full_adder.sv
// Bench for bit4_full_adder: directed vector table followed by random operands checked against an arithmetic model.
module tb_bit4_full_adder;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [3:0] i_a = 4'h0;
  logic [3:0] i_b = 4'h0;
  logic       i_cin = 1'b0;
  logic [3:0] o_sum;
  logic       o_carry;
  logic       o_valid;

  int total = 0;
  int bad = 0;

  logic [4:0] m_res = 5'd0;
  logic       m_vld = 1'b0;

  always #5 i_clk = ~i_clk;

  bit4_full_adder dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_sum   (o_sum),
    .o_carry (o_carry),
    .o_valid (o_valid)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_carry;
    logic       exp_valid;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic vld, input logic [3:0] a,
                              input logic [3:0] b, input logic cin, input logic [3:0] es,
                              input logic ec, input logic ev);
    vec_t v;
    v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.cin = cin;
    v.exp_sum = es; v.exp_carry = ec; v.exp_valid = ev;
    return v;
  endfunction

  // Called at a falling edge: drive, let one rising edge pass, update the model, return at the next falling edge.
  task automatic apply(input logic rst, input logic vld, input logic [3:0] a,
                       input logic [3:0] b, input logic cin);
    i_rst = rst; i_valid = vld; i_a = a; i_b = b; i_cin = cin;
    @(posedge i_clk);
    if (rst) begin
      m_res = 5'd0;
      m_vld = 1'b0;
    end else if (vld) begin
      m_res = 5'(a) + 5'(b) + 5'(cin);
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    @(negedge i_clk);
  endtask

  task automatic check(input string name, input logic [3:0] es, input logic ec, input logic ev);
    total++;
    if (o_sum !== es || o_carry !== ec || o_valid !== ev) begin
      bad++;
      $display("FAIL %s: got sum=%h carry=%b valid=%b, want sum=%h carry=%b valid=%b",
               name, o_sum, o_carry, o_valid, es, ec, ev);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 4'hA, 4'h5, 0, 4'h0, 0, 0);
    vecs[1]  = mk(1, 1, 4'hA, 4'h5, 0, 4'h0, 0, 0);
    vecs[2]  = mk(0, 0, 4'hA, 4'h5, 0, 4'h0, 0, 0);
    vecs[3]  = mk(0, 1, 4'hF, 4'h0, 1, 4'h0, 1, 1);
    vecs[4]  = mk(0, 1, 4'hF, 4'hF, 1, 4'hF, 1, 1);
    vecs[5]  = mk(0, 1, 4'h9, 4'h6, 0, 4'hF, 0, 1);
    vecs[6]  = mk(0, 1, 4'h7, 4'h8, 1, 4'h0, 1, 1);
    vecs[7]  = mk(0, 1, 4'h3, 4'h4, 0, 4'h7, 0, 1);
    vecs[8]  = mk(0, 0, 4'hF, 4'hF, 0, 4'h7, 0, 0);
    vecs[9]  = mk(0, 1, 4'h0, 4'h1, 0, 4'h1, 0, 1);
    vecs[10] = mk(0, 1, 4'h1, 4'h1, 0, 4'h2, 0, 1);
    vecs[11] = mk(1, 1, 4'h2, 4'h1, 0, 4'h0, 0, 0);
    vecs[12] = mk(0, 1, 4'h2, 4'h2, 0, 4'h4, 0, 1);
    vecs[13] = mk(0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1);

    @(negedge i_clk);
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rst, vecs[i].vld, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_valid);
    end

    // Outputs must hold across an idle cycle, then accept again without bubbles.
    apply(0, 1, 4'hC, 4'h5, 1);
    check("idle_pre", 4'h2, 1'b1, 1'b1);
    apply(0, 0, 4'h1, 4'h1, 1);
    check("idle_hold", 4'h2, 1'b1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      apply(0, 1, ra, rb, rc);
      check($sformatf("rand%0d_%h+%h+%b", n, ra, rb, rc), m_res[3:0], m_res[4], m_vld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
